// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: receiver FSM states, frame width, screen size
// and the field clamp helper used when CURSOR_CLAMP_EN is defined.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    localparam int FRAME_BITS = 32;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    // Limit a 16-bit coordinate field to the largest legal screen value.
    function automatic logic [9:0] clamp_field(input logic [15:0] field,
                                               input logic [9:0]  limit);
        if (field > {6'd0, limit})
            return limit;
        else
            return field[9:0];
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous PIC signal into vgaclk.
module sync2 (
    input  logic vgaclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cursor_spi_rx.sv
// SPI receiver for cursor coordinates sent by the PIC. A frame is 32 bits,
// x in bits 31:16 and y in bits 15:0, MSB first, framed by load. Good
// frames land in a pending register that is committed to xcursor/ycursor
// on the next vsync falling edge, so the cursor never moves mid-frame.
// Optional build macro: CURSOR_CLAMP_EN (clamp x/y to XMAX/YMAX).
module cursor_spi_rx
    import vga_pkg::*;
#(
    parameter logic [9:0] XMAX = 10'd639,
    parameter logic [9:0] YMAX = 10'd479
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       sdi,
    input  logic       load,
    input  logic       vsync,
    output logic [9:0] xcursor,
    output logic [9:0] ycursor,
    output logic       frame_err
);

`ifdef CURSOR_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic       sclk_s, sdi_s, load_s;
    logic       sclk_prev, load_prev, vsync_prev;
    logic       sclk_rise, load_rise, load_fall, vsync_fall;
    rx_state_t  state, state_next;
    logic [31:0] shift_reg;
    logic [5:0]  bit_cnt;
    logic [9:0]  pending_x, pending_y;
    logic        pending_valid;
    logic [9:0]  frame_x, frame_y;
    logic        frame_ok, frame_bad;

    sync2 u_sync_sclk (.vgaclk(vgaclk), .reset(reset), .d(sclk), .q(sclk_s));
    sync2 u_sync_sdi  (.vgaclk(vgaclk), .reset(reset), .d(sdi),  .q(sdi_s));
    sync2 u_sync_load (.vgaclk(vgaclk), .reset(reset), .d(load), .q(load_s));

    // Previous-cycle copies used for edge detection on the synchronized inputs.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            sclk_prev  <= 1'b0;
            load_prev  <= 1'b0;
            vsync_prev <= 1'b0;
        end else begin
            sclk_prev  <= sclk_s;
            load_prev  <= load_s;
            vsync_prev <= vsync;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign load_rise  = load_s & ~load_prev;
    assign load_fall  = ~load_s & load_prev;
    assign vsync_fall = vsync_prev & ~vsync;

    // Field extraction; the clamped form is only selected in clamp builds.
    assign frame_x = CLAMP_EN ? clamp_field(shift_reg[31:16], XMAX) : shift_reg[25:16];
    assign frame_y = CLAMP_EN ? clamp_field(shift_reg[15:0],  YMAX) : shift_reg[9:0];

    // FSM state register.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic plus CHECK-cycle verdict on the received bit count.
    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE:  if (load_rise) state_next = SHIFT;
            SHIFT: if (load_fall) state_next = CHECK;
            CHECK: begin
                state_next = IDLE;
                if (bit_cnt == 6'(FRAME_BITS))
                    frame_ok = 1'b1;
                else
                    frame_bad = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register and saturating bit counter; cleared at the start of a frame.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == IDLE && load_rise) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == SHIFT && sclk_rise) begin
            shift_reg <= {shift_reg[30:0], sdi_s};
            if (bit_cnt != 6'd33)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Pending capture and vsync commit; a CHECK coinciding with a commit
    // re-arms pending_valid so the new frame waits for the next vsync fall.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            pending_x     <= '0;
            pending_y     <= '0;
            pending_valid <= 1'b0;
            xcursor       <= '0;
            ycursor       <= '0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            if (vsync_fall && pending_valid) begin
                xcursor       <= pending_x;
                ycursor       <= pending_y;
                pending_valid <= 1'b0;
            end
            if (frame_ok) begin
                pending_x     <= frame_x;
                pending_y     <= frame_y;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule
